// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge-to-pulse converter: edge-mode encodings and
// the pulse counter width helper.
package edge_pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold PW-1; one extra value keeps PW=1 at a legal width of 1.
    function automatic int calc_cw(input int pw);
        return $clog2(pw + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: optional synchroniser, edge detect with runtime mode, retriggerable
// pulse stretcher and sticky flag.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int SYNC = 2,
    parameter int PW   = 1,
    parameter int CW   = calc_cw(PW)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       mask_i,
    input  logic       clear_i,
    output logic       out_o,
    output logic       flag_o
);

    logic          in_s;
    logic          prev_q;
    logic          rise, fall, rise_en, fall_en, det;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          flag_q, flag_d;

    generate
        if (SYNC == 0) begin : g_nosync
            assign in_s = in_i;
        end else begin : g_sync
            logic [SYNC-1:0] sync_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= in_i;
                    for (int j = 1; j < SYNC; j++) sync_q[j] <= sync_q[j-1];
                end
            end
            assign in_s = sync_q[SYNC-1];
        end
    endgenerate

    assign rise    = in_s & ~prev_q;
    assign fall    = ~in_s & prev_q;
    assign rise_en = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
    assign fall_en = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
    assign det     = ~mask_i & ((rise & rise_en) | (fall & fall_en));

    // A detection always reloads, so back-to-back edges stretch one pulse.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (det) begin
            out_d = 1'b1;
            cnt_d = CW'(PW - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            out_d = 1'b0;
        end
        flag_d = det | (flag_q & ~clear_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            prev_q <= in_s;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            flag_q <= flag_d;
        end
    end

    assign out_o  = out_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse converter: DW independent channels sharing one
// startup mask that hides the bogus edge seen while sync chain and prev fill.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int DW   = 1,
    parameter int SYNC = 2,
    parameter int PW   = 1,
    parameter int CW   = calc_cw(PW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   in,
    input  logic [2*DW-1:0] mode,
    input  logic [DW-1:0]   clear,
    output logic [DW-1:0]   out,
    output logic [DW-1:0]   flag,
    output logic            any
);

    localparam int          MW        = $clog2(SYNC + 2);
    localparam logic [MW-1:0] MASK_DONE = MW'(SYNC + 1);

    logic [MW-1:0] mask_q, mask_d;
    logic          masked;

    assign masked = (mask_q != MASK_DONE);
    assign mask_d = masked ? mask_q + 1'b1 : mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mask_q <= '0;
        else       mask_q <= mask_d;
    end

    for (genvar i = 0; i < DW; i++) begin : g_chan
        edge_pulse_chan #(
            .SYNC (SYNC),
            .PW   (PW),
            .CW   (CW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .in_i    (in[i]),
            .mode_i  (mode[2*i +: 2]),
            .mask_i  (masked),
            .clear_i (clear[i]),
            .out_o   (out[i]),
            .flag_o  (flag[i])
        );
    end

    assign any = |out;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen (DW=4, SYNC=2, PW=3): directed tables and sequences
// plus randomized traffic against a history-based reference model.
module tb_edge_pulse_gen;
    import edge_pulse_pkg::*;

    localparam int DW = 4, SYNC = 2, PW = 3, MAXE = 8192;

    logic            clk = 1'b0, reset = 1'b1;
    logic [DW-1:0]   in_r = '0, clear_r = '0;
    logic [2*DW-1:0] mode_r = '0;
    logic [DW-1:0]   out_w, flag_w;
    logic            any_w;

    edge_pulse_gen #(.DW(DW), .SYNC(SYNC), .PW(PW)) dut (
        .clk(clk), .reset(reset), .in(in_r), .mode(mode_r), .clear(clear_r),
        .out(out_w), .flag(flag_w), .any(any_w)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: input history indexed by clock edge since reset release; the
    // synchronised value at edge e is the input sampled SYNC edges earlier.
    int            e;
    logic [DW-1:0] h_in  [MAXE];
    logic [DW-1:0] h_det [MAXE];
    logic [DW-1:0] m_flag;

    function automatic logic [DW-1:0] hv(input int n);
        return (n < 1) ? '0 : h_in[n];
    endfunction

    function automatic logic [DW-1:0] m_out();
        logic [DW-1:0] r = '0;
        for (int j = 0; j < PW; j++) if (e - j >= 1) r |= h_det[e-j];
        return r;
    endfunction

    task automatic m_reset();
        e = 0;
        m_flag = '0;
    endtask

    task automatic model_edge();
        logic s, p, d;
        logic [1:0] m;
        e++;
        h_in[e] = in_r;
        for (int ch = 0; ch < DW; ch++) begin
            s = hv(e - SYNC)[ch];
            p = hv(e - SYNC - 1)[ch];
            m = mode_r[2*ch +: 2];
            d = (e > SYNC + 1) &&
                ((s && !p && (m == MODE_RISE || m == MODE_BOTH)) ||
                 (!s && p && (m == MODE_FALL || m == MODE_BOTH)));
            h_det[e][ch] = d;
            m_flag[ch] = d | (m_flag[ch] & ~clear_r[ch]);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        logic [DW-1:0] mo;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        mo = m_out();
        chk("model_out", 8'(out_w), 8'(mo));
        chk("model_flag", 8'(flag_w), 8'(m_flag));
        chk("model_any", 8'(any_w), 8'(|mo));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        chk("rst_out", 8'(out_w), 8'h00);
        chk("rst_flag", 8'(flag_w), 8'h00);
        chk("rst_any", 8'(any_w), 8'h00);
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    int   cnt_hi, cnt_pl;
    logic cnt_last;
    task automatic count_cycles(input int n, input int ch);
        for (int k = 0; k < n; k++) begin
            cyc();
            if (out_w[ch]) cnt_hi++;
            if (out_w[ch] && !cnt_last) cnt_pl++;
            cnt_last = out_w[ch];
        end
    endtask
    task automatic count_start();
        cnt_hi = 0; cnt_pl = 0; cnt_last = 1'b0;
    endtask

    typedef struct {
        logic [3:0] in;
        logic [7:0] mode;
        logic [3:0] clr;
        logic [3:0] eout;
        logic [3:0] eflag;
    } vec_t;
    vec_t tv [7];

    initial begin
        logic [DW-1:0] seen_out, seen_flag;

        // ch0 RISE, in[0] rises before edge k: pulse after k+2..k+4
        tv[0] = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h0};
        tv[1] = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h0};
        tv[2] = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h1};
        tv[3] = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h1};
        tv[4] = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h1};
        tv[5] = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h1};
        tv[6] = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h1};

        m_reset();
        in_r = 4'hF; mode_r = 8'hFF; clear_r = '0; reset = 1'b1;
        #2;
        chk("rst_out_init", 8'(out_w), 8'h00);
        chk("rst_flag_init", 8'(flag_w), 8'h00);
        repeat (3) cyc();
        reset = 1'b0;
        seen_out = '0; seen_flag = '0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            seen_out |= out_w;
            seen_flag |= flag_w;
        end
        chk("held_high_out", 8'(seen_out), 8'h00);
        chk("held_high_flag", 8'(seen_flag), 8'h00);

        // Table: ch0 rise latency and pulse width
        in_r = '0; mode_r = 8'h01;
        do_reset();
        repeat (5) cyc();
        for (int i = 0; i < 7; i++) begin
            in_r = tv[i].in; mode_r = tv[i].mode; clear_r = tv[i].clr;
            cyc();
            chk("tv_out", 8'(out_w), 8'(tv[i].eout));
            chk("tv_flag", 8'(flag_w), 8'(tv[i].eflag));
            chk("tv_any", 8'(any_w), 8'(|tv[i].eout));
        end

        // ch1 FALL then BOTH
        in_r = '0; mode_r = 8'h08; clear_r = '0;
        do_reset();
        repeat (5) cyc();
        count_start();
        in_r = 4'h2; count_cycles(10, 1);
        in_r = 4'h0; count_cycles(10, 1);
        chk("fall_hi", 8'(cnt_hi), 8'd3);
        chk("fall_pulses", 8'(cnt_pl), 8'd1);
        mode_r = 8'h0C;
        count_start();
        in_r = 4'h2; count_cycles(10, 1);
        in_r = 4'h0; count_cycles(10, 1);
        chk("both_hi", 8'(cnt_hi), 8'd6);
        chk("both_pulses", 8'(cnt_pl), 8'd2);

        // ch2 retrigger: rises two cycles apart merge into one 5-cycle pulse
        mode_r = 8'h10;
        repeat (3) cyc();
        count_start();
        in_r = 4'h4; count_cycles(1, 2);
        in_r = 4'h0; count_cycles(1, 2);
        in_r = 4'h4; count_cycles(9, 2);
        chk("retrig_hi", 8'(cnt_hi), 8'd5);
        chk("retrig_pulses", 8'(cnt_pl), 8'd1);
        in_r = 4'h0;

        // ch3 clear vs det
        mode_r = 8'h40;
        repeat (6) cyc();
        in_r = 4'h8;
        repeat (2) cyc();
        clear_r = 4'h8;
        cyc();
        chk("clr_with_det_out", 8'(out_w[3]), 8'h01);
        chk("clr_with_det_flag", 8'(flag_w[3]), 8'h01);
        cyc();
        chk("clr_alone_flag", 8'(flag_w[3]), 8'h00);
        clear_r = '0;
        in_r = '0;

        // Reset mid-pulse and startup masking
        mode_r = 8'h01;
        do_reset();
        repeat (5) cyc();
        in_r = 4'h1;
        repeat (3) cyc();
        chk("pulse_on", 8'(out_w[0]), 8'h01);
        reset = 1'b1;
        #1;
        m_reset();
        chk("midrst_out", 8'(out_w), 8'h00);
        chk("midrst_flag", 8'(flag_w), 8'h00);
        chk("midrst_any", 8'(any_w), 8'h00);
        in_r = 4'h0;
        repeat (2) cyc();
        reset = 1'b0;
        in_r = 4'h1;
        count_start();
        count_cycles(6, 0);
        chk("masked_edge_hi", 8'(cnt_hi), 8'd0);
        in_r = 4'h0;
        repeat (3) cyc();
        in_r = 4'h1;
        count_start();
        count_cycles(8, 0);
        chk("post_mask_hi", 8'(cnt_hi), 8'd3);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            in_r ^= DW'($urandom & $urandom);
            if ($urandom_range(7) == 0) mode_r = 8'($urandom);
            clear_r = DW'($urandom & $urandom & $urandom);
            if ($urandom_range(299) == 0) do_reset();
            else cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
